// File: rtl/pll_phase_sweep_ctrl.sv
// Dynamic phase-shift sequencer for a PLL: issues a sweep of phase_en pulses,
// tracks the cumulative phase position and guards every handshake with lock and timeout checks.
module pll_phase_sweep_ctrl #(
  parameter int STEP_W  = 8,
  parameter int EN_HOLD = 2,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [4:0]        cntsel_in,
  input  logic              abort,
  input  logic              locked,
  input  logic              phase_done,
  output logic              phase_en,
  output logic              updn,
  output logic [4:0]        cntsel,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [STEP_W-1:0] steps_done,
  output logic [15:0]       pos
);

  localparam int CNT_W = 16;
  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(EN_HOLD - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_LOCK = 4'd1,
    S_SETUP     = 4'd2,
    S_PULSE     = 4'd3,
    S_WAIT_ACK  = 4'd4,
    S_WAIT_DONE = 4'd5,
    S_GAP_W     = 4'd6,
    S_FINISH    = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic              phase_en_q, phase_en_d, updn_q, updn_d, busy_q, busy_d;
  logic              done_q, done_d, error_q, error_d, abort_q, abort_d;
  logic              dir_q, dir_d;
  logic [4:0]        cntsel_q, cntsel_d, cntsel_lat_q, cntsel_lat_d;
  logic [STEP_W-1:0] steps_q, steps_d, num_q, num_d;
  logic [15:0]       pos_q, pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state and next-output computation; outputs are decoded from the next state.
  always_comb begin
    state_d      = state_q;
    updn_d       = updn_q;
    cntsel_d     = cntsel_q;
    error_d      = error_q;
    abort_d      = abort_q | (abort & busy_q);
    dir_d        = dir_q;
    cntsel_lat_d = cntsel_lat_q;
    steps_d      = steps_q;
    num_d        = num_q;
    pos_d        = pos_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          dir_d        = dir;
          num_d        = num_steps;
          cntsel_lat_d = cntsel_in;
          steps_d      = {STEP_W{1'b0}};
          error_d      = 1'b0;
          abort_d      = 1'b0;
          state_d      = S_WAIT_LOCK;
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT_LOCK: begin
        if (num_q == {STEP_W{1'b0}} || abort || abort_q) begin
          state_d = S_FINISH;
        end else if (locked) begin
          cntsel_d = cntsel_lat_q;
          updn_d   = dir_q;
          state_d  = S_SETUP;
        end else begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_SETUP: begin
        if (!locked) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (!locked) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_ACK: begin
        if (!locked) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else if (!phase_done) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!locked) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else if (phase_done) begin
          steps_d = steps_q + STEP_ONE;
          pos_d   = updn_q ? (pos_q + 16'd1) : (pos_q - 16'd1);
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_GAP_W;
        end else if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP_W: begin
        if (!locked) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          // abort arriving on the very last gap cycle still ends the sweep here
          if (steps_q == num_q || abort_q || abort) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FINISH: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_FINISH) begin
      cntsel_d = 5'd0;
    end else begin
      cntsel_d = cntsel_d;
    end
    phase_en_d = (state_d == S_PULSE);
    done_d     = (state_d == S_FINISH);
    busy_d     = (state_d != S_IDLE) && (state_d != S_ERR);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_en_q   <= 1'b0;
      updn_q       <= 1'b1;
      cntsel_q     <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      abort_q      <= 1'b0;
      dir_q        <= 1'b1;
      cntsel_lat_q <= 5'd0;
      steps_q      <= {STEP_W{1'b0}};
      num_q        <= {STEP_W{1'b0}};
      pos_q        <= 16'd0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      phase_en_q   <= phase_en_d;
      updn_q       <= updn_d;
      cntsel_q     <= cntsel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      abort_q      <= abort_d;
      dir_q        <= dir_d;
      cntsel_lat_q <= cntsel_lat_d;
      steps_q      <= steps_d;
      num_q        <= num_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
    end
  end

  assign phase_en   = phase_en_q;
  assign updn       = updn_q;
  assign cntsel     = cntsel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign steps_done = steps_q;
  assign pos        = pos_q;

endmodule

// File: tb/tb_pll_phase_sweep_ctrl.sv
// Directed bench for pll_phase_sweep_ctrl with a simple PLL handshake responder.
module tb_pll_phase_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, dir, abort, locked;
  logic       phase_done;
  logic [7:0] num_steps;
  logic [4:0] cntsel_in;
  logic       phase_en, updn, busy, done, error;
  logic [4:0] cntsel;
  logic [7:0] steps_done;
  logic [15:0] pos;

  logic pll_ack;
  int   vectors = 0;
  int   miscompares = 0;

  int   pulse_cnt = 0, en_up = 0, en_dn = 0, done_cnt = 0;
  logic [4:0] cntsel_at_en = 5'd0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  pll_phase_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .num_steps(num_steps),
    .cntsel_in(cntsel_in), .abort(abort), .locked(locked), .phase_done(phase_done),
    .phase_en(phase_en), .updn(updn), .cntsel(cntsel), .busy(busy), .done(done),
    .error(error), .steps_done(steps_done), .pos(pos)
  );

  // PLL model: after each phase_en pulse, phase_done goes low for 4 cycles.
  initial begin
    phase_done = 1'b1;
    forever begin
      @(negedge clk);
      if (pll_ack && phase_en) begin
        for (int k = 0; k < 40 && phase_en; k++) @(negedge clk);
        phase_done = 1'b0;
        repeat (4) @(negedge clk);
        phase_done = 1'b1;
      end
    end
  end

  // Pulse / done bookkeeping.
  always @(negedge clk) begin
    prev_en <= phase_en;
    if (phase_en && !prev_en) pulse_cnt <= pulse_cnt + 1;
    if (phase_en) begin
      if (updn) en_up <= en_up + 1;
      else en_dn <= en_dn + 1;
      cntsel_at_en <= cntsel;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic d, input logic [7:0] n, input logic [4:0] cs);
    dir = d; num_steps = n; cntsel_in = cs; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int waited);
    waited = 0;
    while (!done && waited < budget) begin
      tick();
      waited++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  int p0, u0, d0, dc0, n;

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; num_steps = 8'd0; cntsel_in = 5'd0;
    abort = 1'b0; locked = 1'b1; pll_ack = 1'b1;
    repeat (3) tick();
    check("rst_phase_en", {31'd0, phase_en}, 32'd0);
    check("rst_updn", {31'd0, updn}, 32'd1);
    check("rst_cntsel", {27'd0, cntsel}, 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
    check("rst_steps_pos", {8'd0, steps_done, pos}, 32'd0);

    reset = 1'b0;
    repeat (5) tick();
    check("idle_quiet", {31'd0, busy | phase_en}, 32'd0);
    check("idle_no_pulse", pulse_cnt, 32'd0);

    // Three steps up on counter 1.
    p0 = pulse_cnt; u0 = en_up; d0 = en_dn; dc0 = done_cnt;
    do_start(1'b1, 8'd3, 5'b00001);
    wait_done("up3_done", 300, n);
    check("up3_cntsel_finish", {27'd0, cntsel}, 32'd0);
    check("up3_steps", {24'd0, steps_done}, 32'd3);
    check("up3_pos", {16'd0, pos}, 32'h0003);
    tick();
    check("up3_done_1cyc", {30'd0, done, busy}, 32'd0);
    check("up3_pulses", pulse_cnt - p0, 32'd3);
    check("up3_en_up_cycles", en_up - u0, 32'd6);
    check("up3_en_dn_cycles", en_dn - d0, 32'd0);
    check("up3_cntsel_at_en", {27'd0, cntsel_at_en}, 32'd1);
    check("up3_done_count", done_cnt - dc0, 32'd1);

    // Five steps down.
    p0 = pulse_cnt; u0 = en_up; d0 = en_dn;
    do_start(1'b0, 8'd5, 5'b00010);
    wait_done("dn5_done", 500, n);
    check("dn5_steps", {24'd0, steps_done}, 32'd5);
    check("dn5_pos", {16'd0, pos}, 32'h0000FFFE);
    tick();
    check("dn5_pulses", pulse_cnt - p0, 32'd5);
    check("dn5_en_dn_cycles", en_dn - d0, 32'd10);
    check("dn5_en_up_cycles", en_up - u0, 32'd0);
    check("dn5_cntsel_at_en", {27'd0, cntsel_at_en}, 32'd2);

    // Zero-step sweep.
    p0 = pulse_cnt;
    do_start(1'b1, 8'd0, 5'b00011);
    wait_done("zero_done", 10, n);
    check("zero_latency_le3", {31'd0, (n + 1) <= 3}, 32'd1);
    check("zero_pos", {16'd0, pos}, 32'h0000FFFE);
    check("zero_steps", {24'd0, steps_done}, 32'd0);
    tick();
    check("zero_no_pulse", pulse_cnt - p0, 32'd0);

    // Missing handshake: WAIT_ACK timeout.
    pll_ack = 1'b0;
    do_start(1'b1, 8'd1, 5'b00001);
    n = 0;
    while (!phase_en && n < 20) begin tick(); n++; end
    check("to_pulse_seen", {31'd0, phase_en}, 32'd1);
    n = 0;
    while (phase_en && n < 20) begin tick(); n++; end
    n = 0;
    while (!error && n < 400) begin tick(); n++; end
    check("to_wait_cycles", n, 32'd255);
    check("to_err_state", {29'd0, error, busy, phase_en}, 32'b100);
    check("to_keep_pos", {16'd0, pos}, 32'h0000FFFE);
    check("to_keep_steps", {24'd0, steps_done}, 32'd0);
    pll_ack = 1'b1;
    do_start(1'b1, 8'd1, 5'b00001);
    check("to_err_cleared", {30'd0, error, busy}, 32'b01);
    wait_done("to_restart_done", 200, n);
    check("to_restart_pos", {16'd0, pos}, 32'h0000FFFF);

    // Abort during step 4 of 10.
    repeat (2) tick();
    p0 = pulse_cnt; dc0 = done_cnt;
    do_start(1'b1, 8'd10, 5'b00100);
    n = 0;
    while (!((pulse_cnt - p0) == 4 && !phase_done) && n < 600) begin tick(); n++; end
    check("ab_reach_step4", pulse_cnt - p0, 32'd4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("ab_done", 200, n);
    check("ab_steps", {24'd0, steps_done}, 32'd4);
    check("ab_pos", {16'd0, pos}, 32'h0003);
    repeat (20) tick();
    check("ab_pulses", pulse_cnt - p0, 32'd4);
    check("ab_single_done", done_cnt - dc0, 32'd1);

    // Lock loss during PULSE.
    do_start(1'b0, 8'd2, 5'b00001);
    n = 0;
    while (!phase_en && n < 20) begin tick(); n++; end
    locked = 1'b0;
    tick();
    check("ll_phase_en_low", {31'd0, phase_en}, 32'd0);
    check("ll_err", {30'd0, error, busy}, 32'b10);
    check("ll_pos_kept", {16'd0, pos}, 32'h0003);
    locked = 1'b1;
    repeat (8) tick();

    // Asynchronous reset in WAIT_DONE.
    p0 = pulse_cnt;
    do_start(1'b1, 8'd3, 5'b00001);
    n = 0;
    while (!((pulse_cnt - p0) == 1 && !phase_done) && n < 100) begin tick(); n++; end
    tick();
    check("rs_in_wait_done", {30'd0, busy, phase_done}, 32'b10);
    #2 reset = 1'b1;
    #1;
    check("rs_async_ctrl", {24'd0, phase_en, updn, busy, done, error, 3'd0}, {24'd0, 8'b01000000});
    check("rs_async_cntsel", {27'd0, cntsel}, 32'd0);
    check("rs_async_steps_pos", {8'd0, steps_done, pos}, 32'd0);
    dc0 = done_cnt;
    repeat (3) tick();
    reset = 1'b0;
    repeat (12) tick();
    check("rs_no_done", done_cnt - dc0, 32'd0);
    check("rs_idle", {30'd0, busy, phase_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
